// File: rtl/raster_block_reorder_pkg.sv
// Shared geometry and bank bookkeeping types for the raster-to-8x8-block reorder buffer.
package raster_block_reorder_pkg;

  localparam int IMG_W      = 32;
  localparam int BLK        = 8;
  localparam int BANK_DEPTH = BLK * IMG_W;
  localparam int ADDR_W     = $clog2(BANK_DEPTH);

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAINING
  } bank_state_e;

endpackage

// File: rtl/reorder_ram.sv
// Two strip banks of pixel storage: one write port, one registered read port with hold.
module reorder_ram
  import raster_block_reorder_pkg::*;
#(
  parameter int DEPTH = BANK_DEPTH,
  parameter int AW    = ADDR_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic          wbank,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic          rbank,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem_q [2][DEPTH];
  logic [7:0] rd_data_q;

  // Read data holds while re is low so a stalled pipeline keeps its pixel.
  always_ff @(posedge clk) begin
    if (we) mem_q[wbank][waddr] <= wdata;
    if (re) rd_data_q <= mem_q[rbank][raddr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/raster_block_reorder.sv
// Buffers BLK-row raster strips in two banks and replays each strip in BLKxBLK block order.
module raster_block_reorder #(
  parameter int IMG_W = raster_block_reorder_pkg::IMG_W,
  parameter int BLK   = raster_block_reorder_pkg::BLK
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_pix,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_pix,
  output logic       out_blk_first
);
  import raster_block_reorder_pkg::*;

  localparam int DEPTH = BLK * IMG_W;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(BLK);
  localparam int NB    = IMG_W / BLK;
  localparam int BW    = (NB > 1) ? $clog2(NB) : 1;

  bank_state_e   bank_st_q [2];
  bank_state_e   bank_st_d [2];
  logic          wr_bank_q, wr_bank_d;
  logic [CW-1:0] wr_col_q, wr_col_d;
  logic [RW-1:0] wr_row_q, wr_row_d;
  logic          rd_bank_q, rd_bank_d;
  logic [RW-1:0] rd_col_q, rd_col_d;
  logic [RW-1:0] rd_row_q, rd_row_d;
  logic [BW-1:0] rd_blk_q, rd_blk_d;
  logic          vld_p1_q, vld_p1_d;
  logic          first_p1_q, first_p1_d;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    out_pix_q, out_pix_d;
  logic          out_blk_first_q, out_blk_first_d;

  logic          wr_en, wr_last, rd_en, rd_last, advance;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [7:0]    rd_data;

  always_comb begin
    bank_st_d       = bank_st_q;
    wr_bank_d       = wr_bank_q;
    wr_col_d        = wr_col_q;
    wr_row_d        = wr_row_q;
    rd_bank_d       = rd_bank_q;
    rd_col_d        = rd_col_q;
    rd_row_d        = rd_row_q;
    rd_blk_d        = rd_blk_q;
    vld_p1_d        = vld_p1_q;
    first_p1_d      = first_p1_q;
    out_valid_d     = out_valid_q;
    out_pix_d       = out_pix_q;
    out_blk_first_d = out_blk_first_q;

    in_ready = !reset && (bank_st_q[wr_bank_q] == BANK_EMPTY ||
                          bank_st_q[wr_bank_q] == BANK_FILLING);
    wr_en    = in_valid && in_ready;
    wr_last  = (wr_col_q == CW'(IMG_W - 1)) && (wr_row_q == RW'(BLK - 1));
    wr_addr  = AW'(int'(wr_row_q) * IMG_W + int'(wr_col_q));

    // The whole read pipeline moves together; it freezes only when the output is held.
    advance  = !out_valid_q || out_ready;
    rd_en    = advance && (bank_st_q[rd_bank_q] == BANK_FULL ||
                           bank_st_q[rd_bank_q] == BANK_DRAINING);
    rd_last  = (rd_col_q == RW'(BLK - 1)) && (rd_row_q == RW'(BLK - 1)) &&
               (rd_blk_q == BW'(NB - 1));
    rd_addr  = AW'(int'(rd_row_q) * IMG_W + int'(rd_blk_q) * BLK + int'(rd_col_q));

    if (wr_en) begin
      bank_st_d[wr_bank_q] = wr_last ? BANK_FULL : BANK_FILLING;
      if (wr_col_q == CW'(IMG_W - 1)) begin
        wr_col_d = '0;
        wr_row_d = (wr_row_q == RW'(BLK - 1)) ? '0 : wr_row_q + 1'b1;
      end else begin
        wr_col_d = wr_col_q + 1'b1;
      end
      if (wr_last) wr_bank_d = ~wr_bank_q;
    end

    // Read and write banks are never the same, so both updates can land in one cycle.
    if (rd_en) begin
      bank_st_d[rd_bank_q] = rd_last ? BANK_EMPTY : BANK_DRAINING;
      if (rd_col_q == RW'(BLK - 1)) begin
        rd_col_d = '0;
        if (rd_row_q == RW'(BLK - 1)) begin
          rd_row_d = '0;
          rd_blk_d = (rd_blk_q == BW'(NB - 1)) ? '0 : rd_blk_q + 1'b1;
        end else begin
          rd_row_d = rd_row_q + 1'b1;
        end
      end else begin
        rd_col_d = rd_col_q + 1'b1;
      end
      if (rd_last) rd_bank_d = ~rd_bank_q;
    end

    if (advance) begin
      vld_p1_d        = rd_en;
      first_p1_d      = (rd_row_q == '0) && (rd_col_q == '0);
      out_valid_d     = vld_p1_q;
      out_blk_first_d = vld_p1_q && first_p1_q;
      if (vld_p1_q) out_pix_d = rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bank_st_q       <= '{BANK_EMPTY, BANK_EMPTY};
      wr_bank_q       <= 1'b0;
      wr_col_q        <= '0;
      wr_row_q        <= '0;
      rd_bank_q       <= 1'b0;
      rd_col_q        <= '0;
      rd_row_q        <= '0;
      rd_blk_q        <= '0;
      vld_p1_q        <= 1'b0;
      first_p1_q      <= 1'b0;
      out_valid_q     <= 1'b0;
      out_pix_q       <= '0;
      out_blk_first_q <= 1'b0;
    end else begin
      bank_st_q       <= bank_st_d;
      wr_bank_q       <= wr_bank_d;
      wr_col_q        <= wr_col_d;
      wr_row_q        <= wr_row_d;
      rd_bank_q       <= rd_bank_d;
      rd_col_q        <= rd_col_d;
      rd_row_q        <= rd_row_d;
      rd_blk_q        <= rd_blk_d;
      vld_p1_q        <= vld_p1_d;
      first_p1_q      <= first_p1_d;
      out_valid_q     <= out_valid_d;
      out_pix_q       <= out_pix_d;
      out_blk_first_q <= out_blk_first_d;
    end
  end

  reorder_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk    (clk),
    .we     (wr_en),
    .wbank  (wr_bank_q),
    .waddr  (wr_addr),
    .wdata  (in_pix),
    .re     (rd_en),
    .rbank  (rd_bank_q),
    .raddr  (rd_addr),
    .rd_data(rd_data)
  );

  assign out_valid     = out_valid_q;
  assign out_pix       = out_pix_q;
  assign out_blk_first = out_blk_first_q;

endmodule

// File: tb/tb_raster_block_reorder.sv
// Bench for raster_block_reorder: strip model + output scoreboard, ramp position table, corner sequences.
module tb_raster_block_reorder;

  localparam int IMG_W = 32;
  localparam int BLK   = 8;
  localparam int DEPTH = 256;
  localparam int NBLK  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_pix = 8'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_pix;
  logic       out_blk_first;

  always #5 clk = ~clk;

  raster_block_reorder #(.IMG_W(IMG_W), .BLK(BLK)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pix       (in_pix),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pix      (out_pix),
    .out_blk_first(out_blk_first)
  );

  typedef struct {
    logic [7:0] pix;
    logic       first;
  } exp_t;

  typedef struct {
    int         idx;
    logic [7:0] pix;
    logic       first;
  } vec_t;

  exp_t       sb_q[$];
  logic [7:0] mdl_strip [DEPTH];
  int         mdl_cnt = 0;
  int         acc_cnt = 0;
  logic [7:0] cap_pix [4096];
  logic       cap_first [4096];
  int         out_cnt = 0;
  int         n_pass = 0;
  int         n_total = 0;
  int         rdy_mode = 0;
  int         stall_at = 0;
  int         stall_left = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] hold_pix = 8'd0;
  logic       hold_first = 1'b0;

  function automatic void chk(input string name, input bit ok, input int act, input int req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endfunction

  // Input model and output scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      sb_q.delete();
      mdl_cnt    = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("hold_stable", out_valid && out_pix == hold_pix && out_blk_first == hold_first,
            int'(out_pix), int'(hold_pix));
      prev_stall = out_valid && !out_ready;
      hold_pix   = out_pix;
      hold_first = out_blk_first;
      if (in_valid && in_ready) begin
        mdl_strip[mdl_cnt] = in_pix;
        mdl_cnt++;
        acc_cnt++;
        if (mdl_cnt == DEPTH) begin
          for (int b = 0; b < NBLK; b++)
            for (int r = 0; r < BLK; r++)
              for (int c = 0; c < BLK; c++) begin
                e.pix   = mdl_strip[r*IMG_W + b*BLK + c];
                e.first = (r == 0 && c == 0);
                sb_q.push_back(e);
              end
          mdl_cnt = 0;
        end
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_out", 1'b0, int'(out_pix), -1);
        end else begin
          e = sb_q.pop_front();
          chk("out_pix", out_pix == e.pix, int'(out_pix), int'(e.pix));
          chk("out_blk_first", out_blk_first == e.first, int'(out_blk_first), int'(e.first));
        end
        if (out_cnt < 4096) begin
          cap_pix[out_cnt]   = out_pix;
          cap_first[out_cnt] = out_blk_first;
        end
        out_cnt++;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1: out_ready = 1'b1;
      2: out_ready = 1'($urandom_range(0, 1));
      3: if (out_cnt >= stall_at && stall_left > 0) begin
           out_ready = 1'b0;
           stall_left--;
         end else begin
           out_ready = 1'b1;
         end
      default: out_ready = 1'b0;
    endcase
  end

  task automatic push_pixels(input int n, input bit rnd, input int vprob, output int stalls);
    int  i = 0;
    int  guard = 0;
    bit  acc;
    stalls = 0;
    while (i < n && guard < n * 20 + 2000) begin
      guard++;
      in_valid = (vprob >= 100) || ($urandom_range(0, 99) < vprob);
      in_pix   = rnd ? 8'($urandom) : 8'(i);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (in_valid && !in_ready) stalls++;
      @(posedge clk);
      #1;
      if (acc) i++;
    end
    in_valid = 1'b0;
    if (i < n) chk("push_timeout", 1'b0, i, n);
  endtask

  task automatic wait_drain(input string name, input int limit);
    int g = 0;
    while ((sb_q.size() != 0 || out_valid) && g < limit) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk(name, g < limit, g, limit);
  endtask

  vec_t tbl [12];

  initial begin
    int st;
    int base;
    int gaps;
    int g;
    int firsts;

    tbl[0]  = '{0,   8'd0,   1'b1};
    tbl[1]  = '{1,   8'd1,   1'b0};
    tbl[2]  = '{7,   8'd7,   1'b0};
    tbl[3]  = '{8,   8'd32,  1'b0};
    tbl[4]  = '{9,   8'd33,  1'b0};
    tbl[5]  = '{63,  8'd231, 1'b0};
    tbl[6]  = '{64,  8'd8,   1'b1};
    tbl[7]  = '{72,  8'd40,  1'b0};
    tbl[8]  = '{128, 8'd16,  1'b1};
    tbl[9]  = '{192, 8'd24,  1'b1};
    tbl[10] = '{200, 8'd56,  1'b0};
    tbl[11] = '{255, 8'd255, 1'b0};

    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("in_ready_during_reset", in_ready == 1'b0, int'(in_ready), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready == 1'b1, int'(in_ready), 1);
    chk("rst_out_valid", out_valid == 1'b0, int'(out_valid), 0);
    chk("rst_out_pix", out_pix == 8'd0, int'(out_pix), 0);
    chk("rst_blk_first", out_blk_first == 1'b0, int'(out_blk_first), 0);
    @(posedge clk);
    #1;

    // Ramp strip with latency checks and position table
    rdy_mode = 1;
    base = out_cnt;
    push_pixels(256, 1'b0, 100, st);
    chk("lat_cycle0", out_valid == 1'b0, int'(out_valid), 0);
    @(posedge clk);
    #1;
    chk("lat_cycle1", out_valid == 1'b0, int'(out_valid), 0);
    @(posedge clk);
    #1;
    chk("lat_cycle2", out_valid == 1'b1, int'(out_valid), 1);
    chk("lat_first_pix", out_pix == 8'd0 && out_blk_first, int'(out_pix), 0);
    wait_drain("ramp_drain", 1000);
    chk("ramp_count", out_cnt - base == 256, out_cnt - base, 256);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("ramp_pos%0d", tbl[i].idx),
          cap_pix[base + tbl[i].idx] == tbl[i].pix && cap_first[base + tbl[i].idx] == tbl[i].first,
          int'(cap_pix[base + tbl[i].idx]), int'(tbl[i].pix));
    end
    firsts = 0;
    for (int i = 0; i < 256; i++) if (cap_first[base + i]) firsts++;
    chk("ramp_first_count", firsts == 4, firsts, 4);

    // Consumer stall at output 37
    base = out_cnt;
    stall_at = out_cnt + 37;
    stall_left = 5;
    rdy_mode = 3;
    push_pixels(256, 1'b0, 100, st);
    g = 0;
    while (out_cnt < stall_at && g < 500) begin
      @(posedge clk);
      #2;
      g++;
    end
    @(negedge clk);
    chk("stall_pix37", out_valid && !out_ready && out_pix == 8'd133, int'(out_pix), 133);
    wait_drain("stall_drain", 1000);
    chk("stall_count", out_cnt - base == 256, out_cnt - base, 256);
    rdy_mode = 1;

    // Continuous two strips
    base = out_cnt;
    push_pixels(512, 1'b1, 100, st);
    chk("cont_in_ready_low", st <= 4, st, 4);
    wait_drain("cont_drain", 1000);
    chk("cont_count", out_cnt - base == 512, out_cnt - base, 512);

    // Both banks full with consumer blocked
    rdy_mode = 0;
    @(posedge clk);
    #1;
    base = acc_cnt;
    push_pixels(512, 1'b1, 100, st);
    repeat (6) begin
      in_valid = 1'b1;
      in_pix = 8'($urandom);
      @(negedge clk);
      chk("blocked_in_ready", in_ready == 1'b0, int'(in_ready), 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("blocked_accepts", acc_cnt - base == 512, acc_cnt - base, 512);
    base = out_cnt;
    rdy_mode = 1;
    gaps = 0;
    g = 0;
    while (g < 2000) begin
      @(posedge clk);
      #1;
      g++;
      if (out_cnt >= base + 512) break;
      if (!out_valid) gaps++;
    end
    chk("b2b_no_bubbles", gaps == 0, gaps, 0);
    wait_drain("b2b_drain", 1000);
    chk("b2b_count", out_cnt - base == 512, out_cnt - base, 512);

    // Reset after a partial strip
    push_pixels(100, 1'b1, 100, st);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready_low", in_ready == 1'b0, int'(in_ready), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", in_ready == 1'b1, int'(in_ready), 1);
    chk("midrst_out_valid", out_valid == 1'b0, int'(out_valid), 0);
    @(posedge clk);
    #1;
    base = out_cnt;
    push_pixels(256, 1'b1, 100, st);
    wait_drain("midrst_drain", 1000);
    chk("midrst_count", out_cnt - base == 256, out_cnt - base, 256);

    // Random bubbles on both sides over four strips
    rdy_mode = 2;
    base = out_cnt;
    push_pixels(1024, 1'b1, 50, st);
    wait_drain("rand_drain", 6000);
    chk("rand_count", out_cnt - base == 1024, out_cnt - base, 1024);
    rdy_mode = 1;

    chk("sb_empty", sb_q.size() == 0, sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

endmodule
